// File: rtl/dense.sv
// ============================================================================
// dense -- fully connected layer stage fed by the maxpool feature buffer.
//
// Each neuron o computes sum_k(in[k] * w[o*IN_DIM+k]) plus its bias. The sum
// is rescaled to the shared Q format by an arithmetic right shift, which
// truncates toward minus infinity. The result saturates to DATA_WIDTH and is
// written to the output buffer. All three memories are external and have a
// 1-cycle read latency.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-low reset
//   start     in   single-cycle run request, honoured only when idle
//   in_addr   out  input buffer read address (k)
//   in_en     out  input buffer read enable
//   in_q      in   input data, valid the cycle after in_en
//   w_addr    out  weight read address (o*IN_DIM+k)
//   w_en      out  weight read enable
//   w_q       in   weight data, valid the cycle after w_en
//   b_addr    out  bias read address (o)
//   b_en      out  bias read enable
//   b_q       in   bias data, valid the cycle after b_en
//   out_addr  out  output buffer write address (o)
//   out_en    out  output buffer enable
//   out_we    out  output buffer write enable (always equal to out_en)
//   out_d     out  result data, holds its last written value
//   done      out  one-cycle pulse after the final write
// ============================================================================
module dense #(
    parameter  int DATA_WIDTH = 16,
    parameter  int FRAC_BITS  = 7,
    parameter  int IN_DIM     = 4,
    parameter  int OUT_DIM    = 2,
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(IN_DIM) + 1,
    localparam int IN_AW      = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
    localparam int W_AW       = (IN_DIM*OUT_DIM > 1) ? $clog2(IN_DIM*OUT_DIM) : 1,
    localparam int OUT_AW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [IN_AW-1:0]             in_addr,
    output logic                         in_en,
    input  logic signed [DATA_WIDTH-1:0] in_q,
    output logic [W_AW-1:0]              w_addr,
    output logic                         w_en,
    input  logic signed [DATA_WIDTH-1:0] w_q,
    output logic [OUT_AW-1:0]            b_addr,
    output logic                         b_en,
    input  logic signed [DATA_WIDTH-1:0] b_q,
    output logic [OUT_AW-1:0]            out_addr,
    output logic                         out_en,
    output logic                         out_we,
    output logic signed [DATA_WIDTH-1:0] out_d,
    output logic                         done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(IN_DIM - 1);
    localparam logic [OUT_AW-1:0] O_LAST = OUT_AW'(OUT_DIM - 1);

    // Saturation limits expressed at accumulator width; ~MAX is the most
    // negative DATA_WIDTH value in two's complement.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic [2:0]                  r_state;
    logic [IN_AW-1:0]            r_k;
    logic [OUT_AW-1:0]           r_o;
    logic [W_AW-1:0]             r_wAddr;
    logic                        r_issueD;
    logic                        r_biasD;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [DATA_WIDTH-1:0] r_bias;
    logic signed [DATA_WIDTH-1:0] r_outD;

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prodExt;
    logic signed [ACC_WIDTH-1:0]    w_biasExt;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_shift;
    logic signed [DATA_WIDTH-1:0]   w_result;
    logic                           w_accClear;

    // Sequencer. The weight address runs as a free counter across neurons,
    // because o*IN_DIM+k is simply the running count of issued reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_o     <= '0;
            r_wAddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_k     <= '0;
                        r_o     <= '0;
                        r_wAddr <= '0;
                    end
                end
                S_ISSUE: begin
                    r_wAddr <= r_wAddr + 1'b1;
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_o == O_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_o     <= r_o + 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-return tracking: the data of a read issued in one cycle arrives
    // in the next, so the issue strobes are delayed by one cycle to
    // qualify accumulation and bias capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issueD <= 1'b0;
            r_biasD  <= 1'b0;
            r_bias   <= '0;
        end else begin
            r_issueD <= in_en;
            r_biasD  <= b_en;
            if (r_biasD) begin
                r_bias <= b_q;
            end
        end
    end

    // The accumulator is cleared on every transition into the first issue
    // cycle of a neuron. No read is in flight at that point, so clearing
    // and accumulating never coincide.
    assign w_accClear = ((r_state == S_IDLE) && start) ||
                        ((r_state == S_WRITE) && (r_o != O_LAST));

    assign w_prod    = in_q * w_q;
    assign w_prodExt = {{(ACC_WIDTH - 2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (w_accClear) begin
            r_acc <= '0;
        end else if (r_issueD) begin
            r_acc <= r_acc + w_prodExt;
        end
    end

    // The bias is aligned to the product scale (2*FRAC_BITS fractional bits)
    // before adding. The shift back to FRAC_BITS then floors the result.
    assign w_biasExt = {{(ACC_WIDTH - DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias} <<< FRAC_BITS;
    assign w_sum     = r_acc + w_biasExt;
    assign w_shift   = w_sum >>> FRAC_BITS;

    always_comb begin
        w_result = w_shift[DATA_WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_result = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // out_d must keep showing the last written value between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outD <= '0;
        end else if (r_state == S_WRITE) begin
            r_outD <= w_result;
        end
    end

    // Memory strobes decode directly from state, so a reset forces them low
    // in the same instant that it forces the state to idle.
    always_comb begin
        in_en    = 1'b0;
        w_en     = 1'b0;
        b_en     = 1'b0;
        out_en   = 1'b0;
        out_we   = 1'b0;
        in_addr  = '0;
        w_addr   = '0;
        b_addr   = '0;
        out_addr = '0;
        out_d    = r_outD;
        done     = 1'b0;
        case (r_state)
            S_ISSUE: begin
                in_en   = 1'b1;
                w_en    = 1'b1;
                in_addr = r_k;
                w_addr  = r_wAddr;
                if (r_k == '0) begin
                    b_en   = 1'b1;
                    b_addr = r_o;
                end
            end
            S_WRITE: begin
                out_en   = 1'b1;
                out_we   = 1'b1;
                out_addr = r_o;
                out_d    = w_result;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dense.sv
// ============================================================================
// tb_dense -- self-checking bench for dense (IN_DIM=4, OUT_DIM=2).
//
// Two instances share the same input, weight and bias memories. One uses
// FRAC_BITS=0 and the other FRAC_BITS=7. Each has its own output buffer.
// Expected results come from an arithmetic reference of the layer, and the
// strobe timing is derived from the documented cycle schedule.
// ============================================================================
module tb_dense;

    localparam logic signed [15:0] SENTINEL = 16'sh5A5A;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic clearOut = 1'b0;

    int assertCount = 0;
    int failCount = 0;

    logic signed [15:0] inMem [0:3];
    logic signed [15:0] wMem [0:7];
    logic signed [15:0] bMem [0:1];
    logic signed [15:0] outMem0 [0:1];
    logic signed [15:0] outMem7 [0:1];

    logic [1:0]         in_addr0, in_addr7;
    logic [2:0]         w_addr0, w_addr7;
    logic               b_addr0, b_addr7, out_addr0, out_addr7;
    logic               in_en0, w_en0, b_en0, out_en0, out_we0, done0;
    logic               in_en7, w_en7, b_en7, out_en7, out_we7, done7;
    logic signed [15:0] inQ0, wQ0, bQ0, out_d0;
    logic signed [15:0] inQ7, wQ7, bQ7, out_d7;

    always #5 clk = ~clk;

    dense #(.DATA_WIDTH(16), .FRAC_BITS(0), .IN_DIM(4), .OUT_DIM(2)) u_dense0 (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr0), .in_en(in_en0), .in_q(inQ0),
        .w_addr(w_addr0), .w_en(w_en0), .w_q(wQ0),
        .b_addr(b_addr0), .b_en(b_en0), .b_q(bQ0),
        .out_addr(out_addr0), .out_en(out_en0), .out_we(out_we0),
        .out_d(out_d0), .done(done0)
    );

    dense #(.DATA_WIDTH(16), .FRAC_BITS(7), .IN_DIM(4), .OUT_DIM(2)) u_dense7 (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr7), .in_en(in_en7), .in_q(inQ7),
        .w_addr(w_addr7), .w_en(w_en7), .w_q(wQ7),
        .b_addr(b_addr7), .b_en(b_en7), .b_q(bQ7),
        .out_addr(out_addr7), .out_en(out_en7), .out_we(out_we7),
        .out_d(out_d7), .done(done7)
    );

    // External memories with 1-cycle read latency
    always @(posedge clk) begin
        if (in_en0) inQ0 <= inMem[in_addr0];
        if (w_en0)  wQ0  <= wMem[w_addr0];
        if (b_en0)  bQ0  <= bMem[b_addr0];
        if (in_en7) inQ7 <= inMem[in_addr7];
        if (w_en7)  wQ7  <= wMem[w_addr7];
        if (b_en7)  bQ7  <= bMem[b_addr7];
    end

    // Output buffers; clearOut preloads a sentinel so unwritten slots show
    always @(posedge clk) begin
        if (clearOut) begin
            for (int i = 0; i < 2; i++) begin
                outMem0[i] <= SENTINEL;
                outMem7[i] <= SENTINEL;
            end
        end else begin
            if (out_en0 && out_we0) outMem0[out_addr0] <= out_d0;
            if (out_en7 && out_we7) outMem7[out_addr7] <= out_d7;
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference neuron: exact integer dot product plus scaled bias, floored
    // division by 2^frac, then clamp to the 16-bit signed range.
    function automatic longint refNeuron(input int frac, input int o);
        longint acc = 0;
        longint div = longint'(1) << frac;
        longint r;
        for (int k = 0; k < 4; k++) begin
            acc += longint'(inMem[k]) * longint'(wMem[o*4 + k]);
        end
        acc += longint'(bMem[o]) * div;
        r = acc / div;
        if ((acc < 0) && ((acc % div) != 0)) r -= 1;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // One run: optional extra start pulse at busyCycle, optional reset
    // assertion at resetCycle (held low for two cycles). Cycle 1 is the
    // first cycle after the start edge.
    task automatic applyStimulus(input int busyCycle, input int resetCycle);
        int     seqErr = 0;
        int     doneCnt0 = 0;
        int     doneCnt7 = 0;
        int     pos, o;
        bit     after, active, expIssue, expB, expWr, expDone, written;
        longint exp0, exp7;

        clearOut = 1'b1;
        @(negedge clk);
        clearOut = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (busyCycle > 0 && cyc == busyCycle)     start = 1'b1;
            if (busyCycle > 0 && cyc == busyCycle + 1) start = 1'b0;
            if (resetCycle > 0 && cyc == resetCycle) begin
                reset = 1'b0;
                #1;
                checkOutput("midRstCtl", {in_en0, w_en0, b_en0, out_en0, out_we0, done0,
                                          in_en7, w_en7, b_en7, out_en7, out_we7, done7}, 0);
                checkOutput("midRstData", {in_addr0, w_addr0, b_addr0, out_addr0, out_d0, out_d7}, 0);
            end
            if (resetCycle > 0 && cyc == resetCycle + 2) reset = 1'b1;

            after    = (resetCycle > 0) && (cyc >= resetCycle);
            active   = !after && (cyc <= 12);
            pos      = (cyc - 1) % 6;
            o        = (cyc - 1) / 6;
            expIssue = active && (pos < 4);
            expB     = expIssue && (pos == 0);
            expWr    = active && (pos == 5);
            expDone  = !after && (cyc == 13);

            if ({in_en0, w_en0, b_en0, out_en0, out_we0, done0} !==
                {expIssue, expIssue, expB, expWr, expWr, expDone}) seqErr++;
            if ({in_en7, w_en7, b_en7, out_en7, out_we7, done7} !==
                {expIssue, expIssue, expB, expWr, expWr, expDone}) seqErr++;
            if (expIssue && (int'(in_addr0) != pos || int'(w_addr0) != o*4 + pos)) seqErr++;
            if (expB && int'(b_addr0) != o) seqErr++;
            if (expWr && int'(out_addr0) != o) seqErr++;
            if (done0) doneCnt0++;
            if (done7) doneCnt7++;
            @(negedge clk);
        end

        checkOutput("schedule", seqErr, 0);
        checkOutput("doneCnt0", doneCnt0, (resetCycle > 0) ? 0 : 1);
        checkOutput("doneCnt7", doneCnt7, (resetCycle > 0) ? 0 : 1);
        for (int n = 0; n < 2; n++) begin
            written = (resetCycle == 0) || ((n + 1) * 6 < resetCycle);
            exp0 = written ? refNeuron(0, n) : longint'(SENTINEL);
            exp7 = written ? refNeuron(7, n) : longint'(SENTINEL);
            checkOutput($sformatf("q0out[%0d]", n), outMem0[n], exp0);
            checkOutput($sformatf("q7out[%0d]", n), outMem7[n], exp7);
        end
    endtask

    initial begin
        int v;
        for (int i = 0; i < 4; i++) inMem[i] = '0;
        for (int i = 0; i < 8; i++) wMem[i] = '0;
        for (int i = 0; i < 2; i++) bMem[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("rstCtl", {in_en0, w_en0, b_en0, out_en0, out_we0, done0,
                               in_en7, w_en7, b_en7, out_en7, out_we7, done7}, 0);
        checkOutput("rstAddr", {in_addr0, w_addr0, b_addr0, out_addr0}, 0);
        checkOutput("rstOutD0", out_d0, 0);
        checkOutput("rstOutD7", out_d7, 0);
        reset = 1'b1;
        @(negedge clk);

        // Integer case
        inMem[0] = 5; inMem[1] = 7; inMem[2] = 13; inMem[3] = 15;
        for (int k = 0; k < 4; k++) begin
            wMem[k]     = 16'sd1;
            wMem[4 + k] = (k % 2 == 0) ? 16'sd1 : -16'sd1;
        end
        bMem[0] = 0; bMem[1] = 3;
        applyStimulus(0, 0);
        checkOutput("intOut0", outMem0[0], 40);
        checkOutput("intOut1", outMem0[1], -1);

        // Fractional case: 1.0 * 0.5 summed four times
        for (int k = 0; k < 4; k++) begin
            inMem[k] = 16'sd128;
            wMem[k]  = 16'sd64;
        end
        bMem[0] = 0;
        applyStimulus(0, 0);
        checkOutput("fracOut0", outMem7[0], 256);

        // Floor truncation of a small negative result
        inMem[0] = -16'sd1; inMem[1] = 0; inMem[2] = 0; inMem[3] = 0;
        wMem[0] = 16'sd1; wMem[1] = 0; wMem[2] = 0; wMem[3] = 0;
        applyStimulus(0, 0);
        checkOutput("floorOut0", outMem7[0], -1);

        // Saturation both ways
        for (int k = 0; k < 4; k++) inMem[k] = 16'sd32767;
        for (int k = 0; k < 8; k++) wMem[k] = 16'sd32767;
        bMem[0] = 0; bMem[1] = 0;
        applyStimulus(0, 0);
        checkOutput("satPos0", outMem0[0], 32767);
        checkOutput("satPos7", outMem7[1], 32767);
        for (int k = 0; k < 8; k++) wMem[k] = -16'sd32767;
        applyStimulus(0, 0);
        checkOutput("satNeg0", outMem0[0], -32768);
        checkOutput("satNeg7", outMem7[1], -32768);

        // Random data for the busy-start and mid-run-reset scenarios
        for (int k = 0; k < 4; k++) inMem[k] = 16'(int'($urandom_range(0, 511)) - 256);
        for (int k = 0; k < 8; k++) wMem[k] = 16'(int'($urandom_range(0, 511)) - 256);
        for (int k = 0; k < 2; k++) bMem[k] = 16'(int'($urandom_range(0, 511)) - 256);
        applyStimulus(3, 0);
        applyStimulus(0, 7);
        applyStimulus(0, 0);

        // Randomized runs, alternating full-range and small-magnitude data
        for (int run = 0; run < 8; run++) begin
            for (int k = 0; k < 4; k++) begin
                v = (run % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 1023)) - 512;
                inMem[k] = 16'(v);
            end
            for (int k = 0; k < 8; k++) begin
                v = (run % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 1023)) - 512;
                wMem[k] = 16'(v);
            end
            for (int k = 0; k < 2; k++) begin
                v = (run % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 65535)) - 32768;
                bMem[k] = 16'(v);
            end
            applyStimulus(0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
